// File: rtl/cm_loop_seq_if.sv
// Stream interface between the loop sequencer and its consumer: loop configuration and start in,
// index/address beats with valid/ready out.
interface cm_loop_seq_if #(
   parameter int C_WIDTH  = 8,
   parameter int C_AWIDTH = 16
);
   logic                I_start;
   logic [C_WIDTH-1:0]  I_upper0;
   logic [C_WIDTH-1:0]  I_upper1;
   logic [C_WIDTH-1:0]  I_upper2;
   logic [C_AWIDTH-1:0] I_base;
   logic [C_AWIDTH-1:0] I_stride1;
   logic [C_AWIDTH-1:0] I_stride2;
   logic                I_ready;
   logic                O_valid;
   logic [C_WIDTH-1:0]  O_idx0;
   logic [C_WIDTH-1:0]  O_idx1;
   logic [C_WIDTH-1:0]  O_idx2;
   logic [C_AWIDTH-1:0] O_addr;
   logic                O_last;
   logic                O_busy;
   logic                O_done;

   // master: the sequencer that produces the beats
   modport master (
      input  I_start, I_upper0, I_upper1, I_upper2, I_base, I_stride1, I_stride2, I_ready,
      output O_valid, O_idx0, O_idx1, O_idx2, O_addr, O_last, O_busy, O_done
   );

   modport slave (
      output I_start, I_upper0, I_upper1, I_upper2, I_base, I_stride1, I_stride2, I_ready,
      input  O_valid, O_idx0, O_idx1, O_idx2, O_addr, O_last, O_busy, O_done
   );
endinterface

// File: rtl/cm_loop_seq.sv
// Three-level nested loop sequencer: walks idx0 (inner) .. idx2 (outer) and emits a linear
// address per beat using incremental adds only; every output comes straight from a flop.
module cm_loop_seq #(
   parameter int C_WIDTH  = 8,
   parameter int C_AWIDTH = 16
) (
   input  logic          I_clk,
   input  logic          I_rst,
   cm_loop_seq_if.master bus
);
   localparam logic [C_WIDTH-1:0]  ONE_W = C_WIDTH'(1);
   localparam logic [C_AWIDTH-1:0] ONE_A = C_AWIDTH'(1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   state_t              state_reg;
   logic [C_WIDTH-1:0]  idx_reg   [3];
   logic [C_WIDTH-1:0]  upper_reg [3];
   logic [C_AWIDTH-1:0] stride1_reg;
   logic [C_AWIDTH-1:0] stride2_reg;
   logic [C_AWIDTH-1:0] addr_reg;
   logic [C_AWIDTH-1:0] row_reg;
   logic [C_AWIDTH-1:0] plane_reg;
   logic                valid_reg;
   logic                last_reg;
   logic                busy_reg;
   logic                done_reg;

   logic [C_WIDTH-1:0]  idx_next  [3];
   logic [C_AWIDTH-1:0] addr_next;
   logic [C_AWIDTH-1:0] row_next;
   logic [C_AWIDTH-1:0] plane_next;
   logic [1:0]          lvl_end;
   logic [2:0]          lvl_end_next;
   logic                cfg_zero;
   logic                cfg_single;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_lvl_end
         assign lvl_end[gi] = (idx_reg[gi] == upper_reg[gi] - ONE_W);
      end
      // O_last is registered, so the "final beat" test runs on the indices about to be loaded
      for (gi = 0; gi < 3; gi++) begin : g_lvl_end_next
         assign lvl_end_next[gi] = (idx_next[gi] == upper_reg[gi] - ONE_W);
      end
   endgenerate

   assign cfg_zero   = (bus.I_upper0 == '0) || (bus.I_upper1 == '0) || (bus.I_upper2 == '0);
   assign cfg_single = (bus.I_upper0 == ONE_W) && (bus.I_upper1 == ONE_W) && (bus.I_upper2 == ONE_W);

   always_comb begin
      idx_next[0] = idx_reg[0];
      idx_next[1] = idx_reg[1];
      idx_next[2] = idx_reg[2];
      addr_next   = addr_reg;
      row_next    = row_reg;
      plane_next  = plane_reg;
      if (!lvl_end[0]) begin
         idx_next[0] = idx_reg[0] + ONE_W;
         addr_next   = addr_reg + ONE_A;
      end else if (!lvl_end[1]) begin
         idx_next[0] = '0;
         idx_next[1] = idx_reg[1] + ONE_W;
         row_next    = row_reg + stride1_reg;
         addr_next   = row_next;
      end else begin
         idx_next[0] = '0;
         idx_next[1] = '0;
         idx_next[2] = idx_reg[2] + ONE_W;
         plane_next  = plane_reg + stride2_reg;
         row_next    = plane_next;
         addr_next   = plane_next;
      end
   end

   always_ff @(posedge I_clk or posedge I_rst) begin
      if (I_rst) begin
         state_reg   <= ST_IDLE;
         for (int i = 0; i < 3; i++) begin
            idx_reg[i]   <= '0;
            upper_reg[i] <= '0;
         end
         stride1_reg <= '0;
         stride2_reg <= '0;
         addr_reg    <= '0;
         row_reg     <= '0;
         plane_reg   <= '0;
         valid_reg   <= 1'b0;
         last_reg    <= 1'b0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (bus.I_start) begin
                  upper_reg[0] <= bus.I_upper0;
                  upper_reg[1] <= bus.I_upper1;
                  upper_reg[2] <= bus.I_upper2;
                  stride1_reg  <= bus.I_stride1;
                  stride2_reg  <= bus.I_stride2;
                  for (int i = 0; i < 3; i++) begin
                     idx_reg[i] <= '0;
                  end
                  addr_reg  <= bus.I_base;
                  row_reg   <= bus.I_base;
                  plane_reg <= bus.I_base;
                  busy_reg  <= 1'b1;
                  if (cfg_zero) begin
                     state_reg <= ST_DONE;
                  end else begin
                     state_reg <= ST_RUN;
                     valid_reg <= 1'b1;
                     last_reg  <= cfg_single;
                  end
               end
            end
            ST_RUN: begin
               if (valid_reg && bus.I_ready) begin
                  if (last_reg) begin
                     valid_reg <= 1'b0;
                     last_reg  <= 1'b0;
                     state_reg <= ST_DONE;
                  end else begin
                     for (int i = 0; i < 3; i++) begin
                        idx_reg[i] <= idx_next[i];
                     end
                     addr_reg  <= addr_next;
                     row_reg   <= row_next;
                     plane_reg <= plane_next;
                     last_reg  <= &lvl_end_next;
                  end
               end
            end
            ST_DONE: begin
               done_reg  <= 1'b1;
               busy_reg  <= 1'b0;
               state_reg <= ST_IDLE;
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign bus.O_valid = valid_reg;
   assign bus.O_idx0  = idx_reg[0];
   assign bus.O_idx1  = idx_reg[1];
   assign bus.O_idx2  = idx_reg[2];
   assign bus.O_addr  = addr_reg;
   assign bus.O_last  = last_reg;
   assign bus.O_busy  = busy_reg;
   assign bus.O_done  = done_reg;
endmodule

// File: tb/tb_cm_loop_seq.sv
// Bench for cm_loop_seq: nested-loop reference model (with multiplies) feeding a beat scoreboard,
// checked every cycle, plus literal address/latency expectations for the directed cases.
module tb_cm_loop_seq;
   localparam int W  = 8;
   localparam int AW = 16;

   logic I_clk = 1'b0;
   logic I_rst = 1'b1;

   cm_loop_seq_if #(.C_WIDTH(W), .C_AWIDTH(AW)) bus ();

   cm_loop_seq #(.C_WIDTH(W), .C_AWIDTH(AW)) dut (
      .I_clk (I_clk),
      .I_rst (I_rst),
      .bus   (bus)
   );

   always #5 I_clk = ~I_clk;

   typedef struct {
      logic [W-1:0]  i0;
      logic [W-1:0]  i1;
      logic [W-1:0]  i2;
      logic [AW-1:0] addr;
      logic          last;
   } beat_t;

   beat_t         exp_q[$];
   logic [AW-1:0] obs_q[$];
   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int beats_seen = 0;
   int done_cnt = 0;
   int done_cyc = -1;

   logic [AW-1:0] lit1 [6] = '{16'h0100, 16'h0101, 16'h0102, 16'h0110, 16'h0111, 16'h0112};
   logic [AW-1:0] lit4 [8] = '{16'hFFFE, 16'hFFFF, 16'hFFFF, 16'h0000,
                               16'h0002, 16'h0003, 16'h0003, 16'h0004};

   always @(posedge I_clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference: enumerate the nest directly, address by the closed-form formula.
   task automatic build(input logic [W-1:0] u0, input logic [W-1:0] u1, input logic [W-1:0] u2,
                        input logic [AW-1:0] base, input logic [AW-1:0] s1, input logic [AW-1:0] s2);
      int total;
      int n;
      beat_t b;
      exp_q.delete();
      total = int'(u0) * int'(u1) * int'(u2);
      n = 0;
      for (int i2 = 0; i2 < int'(u2); i2++)
         for (int i1 = 0; i1 < int'(u1); i1++)
            for (int i0 = 0; i0 < int'(u0); i0++) begin
               b.i0   = W'(i0);
               b.i1   = W'(i1);
               b.i2   = W'(i2);
               b.addr = AW'(int'(base) + i0 + i1 * int'(s1) + i2 * int'(s2));
               b.last = (n == total - 1);
               exp_q.push_back(b);
               n++;
            end
   endtask

   // Compare process: every presented beat must equal the scoreboard head; head retires on accept.
   always @(negedge I_clk) begin
      if (!I_rst) begin
         if (bus.O_done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (bus.O_valid) begin
            if (exp_q.size() == 0) begin
               chk("valid_without_expected_beat", bus.O_valid, 1'b0);
            end else begin
               chk("idx0", bus.O_idx0, exp_q[0].i0);
               chk("idx1", bus.O_idx1, exp_q[0].i1);
               chk("idx2", bus.O_idx2, exp_q[0].i2);
               chk("addr", bus.O_addr, exp_q[0].addr);
               chk("last", bus.O_last, exp_q[0].last);
               chk("busy_in_run", bus.O_busy, 1'b1);
               if (bus.I_ready) begin
                  obs_q.push_back(bus.O_addr);
                  void'(exp_q.pop_front());
                  beats_seen++;
               end
            end
         end
      end
   end

   // rmode 0: ready always high; rmode 1: ready 1,0,0 repeating. disturb: restart and retune mid-run.
   task automatic run(input string tag, input logic [W-1:0] u0, input logic [W-1:0] u1,
                      input logic [W-1:0] u2, input logic [AW-1:0] base, input logic [AW-1:0] s1,
                      input logic [AW-1:0] s2, input int rmode, input bit disturb, input int exp_lat);
      int k;
      int c0;
      int nexp;
      build(u0, u1, u2, base, s1, s2);
      nexp = exp_q.size();
      beats_seen = 0;
      done_cnt = 0;
      done_cyc = -1;
      obs_q.delete();
      bus.I_upper0  = u0;
      bus.I_upper1  = u1;
      bus.I_upper2  = u2;
      bus.I_base    = base;
      bus.I_stride1 = s1;
      bus.I_stride2 = s2;
      bus.I_ready   = 1'b1;
      bus.I_start   = 1'b1;
      c0 = cyc;
      k = 0;
      while (done_cnt == 0 && k < 400) begin
         @(posedge I_clk);
         #1;
         k++;
         if (k == 1) chk({tag, "_busy_after_start"}, bus.O_busy, 1'b1);
         bus.I_start = disturb && (k == 3);
         if (disturb && k == 2) begin
            bus.I_upper0 = u0 + 8'd3;
            bus.I_base   = base + 16'h0040;
         end
         bus.I_ready = (rmode == 0) ? 1'b1 : ((k % 3) == 1);
      end
      @(negedge I_clk);
      #1;
      chk({tag, "_done_pulses"}, done_cnt, 1);
      chk({tag, "_beats"}, beats_seen, nexp);
      chk({tag, "_beats_left"}, exp_q.size(), 0);
      chk({tag, "_busy_idle"}, bus.O_busy, 1'b0);
      if (exp_lat >= 0) chk({tag, "_done_latency"}, done_cyc - c0, exp_lat);
      $display("run %s: beats=%0d done_latency=%0d", tag, beats_seen, done_cyc - c0);
   endtask

   initial begin
      int c0;
      bus.I_start   = 1'b0;
      bus.I_upper0  = '0;
      bus.I_upper1  = '0;
      bus.I_upper2  = '0;
      bus.I_base    = '0;
      bus.I_stride1 = '0;
      bus.I_stride2 = '0;
      bus.I_ready   = 1'b0;
      #2;
      chk("reset_outputs", {bus.O_valid, bus.O_last, bus.O_busy, bus.O_done, bus.O_addr,
                            bus.O_idx0, bus.O_idx1, bus.O_idx2}, 32'h0);
      repeat (2) @(posedge I_clk);
      #1 I_rst = 1'b0;
      @(posedge I_clk);
      #1;

      // Pin the model against hand-computed values.
      build(8'd3, 8'd2, 8'd1, 16'h0100, 16'h0010, 16'h0000);
      for (int i = 0; i < 6; i++) chk("model_t1_addr", exp_q[i].addr, lit1[i]);
      chk("model_t1_last", {exp_q[4].last, exp_q[5].last}, 2'b01);
      build(8'd2, 8'd2, 8'd2, 16'hFFFE, 16'h0001, 16'h0004);
      for (int i = 0; i < 8; i++) chk("model_t4_addr", exp_q[i].addr, lit4[i]);

      run("t1_basic", 8'd3, 8'd2, 8'd1, 16'h0100, 16'h0010, 16'h0000, 0, 1'b0, 8);
      for (int i = 0; i < 6; i++)
         chk("t1_dut_addr", (i < obs_q.size()) ? obs_q[i] : 16'hxxxx, lit1[i]);

      run("t2_stall", 8'd3, 8'd2, 8'd1, 16'h0100, 16'h0010, 16'h0000, 1, 1'b0, 18);
      for (int i = 0; i < 6; i++)
         chk("t2_dut_addr", (i < obs_q.size()) ? obs_q[i] : 16'hxxxx, lit1[i]);

      run("t3_single", 8'd1, 8'd1, 8'd1, 16'h0ABC, 16'h0010, 16'h0020, 0, 1'b0, 3);
      chk("t3_single_addr", (obs_q.size() > 0) ? obs_q[0] : 16'hxxxx, 16'h0ABC);
      run("t3_zero", 8'd4, 8'd0, 8'd2, 16'h0100, 16'h0010, 16'h0020, 0, 1'b0, 2);

      run("t4_wrap", 8'd2, 8'd2, 8'd2, 16'hFFFE, 16'h0001, 16'h0004, 0, 1'b0, 10);
      for (int i = 0; i < 8; i++)
         chk("t4_dut_addr", (i < obs_q.size()) ? obs_q[i] : 16'hxxxx, lit4[i]);

      // Reset while beat 3 of 6 is on the outputs.
      build(8'd3, 8'd2, 8'd1, 16'h0100, 16'h0010, 16'h0000);
      done_cnt = 0;
      bus.I_upper0  = 8'd3;
      bus.I_upper1  = 8'd2;
      bus.I_upper2  = 8'd1;
      bus.I_base    = 16'h0100;
      bus.I_stride1 = 16'h0010;
      bus.I_stride2 = 16'h0000;
      bus.I_ready   = 1'b1;
      bus.I_start   = 1'b1;
      c0 = cyc;
      for (int k = 1; k <= 3; k++) begin
         @(posedge I_clk);
         #1;
         bus.I_start = 1'b0;
      end
      chk("t5_beat3_addr", bus.O_addr, 16'h0102);
      I_rst = 1'b1;
      #1;
      chk("t5_outputs_in_reset", {bus.O_valid, bus.O_last, bus.O_busy, bus.O_done, bus.O_addr,
                                  bus.O_idx0, bus.O_idx1, bus.O_idx2}, 32'h0);
      @(posedge I_clk);
      #1 I_rst = 1'b0;
      repeat (10) @(posedge I_clk);
      #1;
      chk("t5_no_done_after_reset", done_cnt, 0);
      chk("t5_idle_after_reset", {bus.O_valid, bus.O_busy}, 2'b00);
      $display("run t5_reset: reset applied %0d cycles after start", cyc - c0);
      run("t5_replay", 8'd3, 8'd2, 8'd1, 16'h0100, 16'h0010, 16'h0000, 0, 1'b0, 8);
      for (int i = 0; i < 6; i++)
         chk("t5_dut_addr", (i < obs_q.size()) ? obs_q[i] : 16'hxxxx, lit1[i]);

      run("t6_ignore", 8'd3, 8'd2, 8'd1, 16'h0100, 16'h0010, 16'h0000, 0, 1'b1, 8);
      for (int i = 0; i < 6; i++)
         chk("t6_dut_addr", (i < obs_q.size()) ? obs_q[i] : 16'hxxxx, lit1[i]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
